arbiter_k: RTL and testbench

- Four-requestor round-robin bus arbiter with grant locking and a bounded hold time.
- Samples four request lines and drives four registered, one-hot (or all-zero) grant lines.
- Sits between four independent masters and one shared resource.
- Fairness: rotating priority pointer, plus a maximum-hold limit that forces rotation under contention.

---
 rtl/arbiter_k.sv | 104 ++++++++++
 tb/tb_arbiter_k.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/arbiter_k.sv
// Four-requestor round-robin arbiter with registered one-hot grants.
// A grant is forcibly rotated after MAX_HOLD cycles when another master is waiting.
//
// state | meaning
// IDLE  | no grant asserted, waiting for any request
// GNT0  | master 0 owns the resource
// GNT1  | master 1 owns the resource
// GNT2  | master 2 owns the resource
// GNT3  | master 3 owns the resource
module arbiter_k #(
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic req2,
    input  logic req3,
    output logic gnt0,
    output logic gnt1,
    output logic gnt2,
    output logic gnt3
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] GNT0 = 3'd1;
    localparam logic [2:0] GNT1 = 3'd2;
    localparam logic [2:0] GNT2 = 3'd3;
    localparam logic [2:0] GNT3 = 3'd4;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);

    logic [2:0] state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [7:0] hold, hold_nxt;
    logic [3:0] req;
    logic [1:0] cur;
    logic [3:0] others;

    assign req    = {req3, req2, req1, req0};
    assign cur    = 2'(state - 3'd1);
    assign others = req & ~(4'b0001 << cur);

    // First asserted request scanning p, p+1, p+2, p+3 (mod 4); lowest offset wins.
    function automatic logic [1:0] sel(input logic [1:0] p, input logic [3:0] r);
        logic [1:0] idx;
        sel = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) sel = idx;
        end
    endfunction

    function automatic logic [2:0] gnt_state(input logic [1:0] i);
        gnt_state = {1'b0, i} + 3'd1;
    endfunction

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = gnt_state(sel(ptr, req));
                    hold_nxt  = 8'd0;
                end
            end
            GNT0, GNT1, GNT2, GNT3: begin
                if (req[cur] && (others == 4'b0000 || hold < HOLD_MAX)) begin
                    if (hold < HOLD_MAX) hold_nxt = hold + 8'd1;
                end else begin
                    // Release or hold expiry: the current owner is excluded from the scan.
                    ptr_nxt  = cur + 2'd1;
                    hold_nxt = 8'd0;
                    if (|others) state_nxt = gnt_state(sel(cur + 2'd1, others));
                    else         state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                hold_nxt  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            hold  <= 8'd0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            hold  <= hold_nxt;
        end
    end

    assign gnt0 = (state == GNT0);
    assign gnt1 = (state == GNT1);
    assign gnt2 = (state == GNT2);
    assign gnt3 = (state == GNT3);

endmodule

// File: tb/tb_arbiter_k.sv
// Bench for arbiter_k: directed vectors feed an expected-grant queue drained by a monitor,
// followed by a random soak checked against one-hot, legality and wait-bound properties.
module tb_arbiter_k;

    localparam int MAX_HOLD = 4;
    localparam int WAIT_BOUND = 3 * MAX_HOLD + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0, req2 = 1'b0, req3 = 1'b0;
    logic gnt0, gnt1, gnt2, gnt3;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];
    int         tag_q[$];
    int         vec_id = 0;
    logic       soak = 1'b0;
    int         wait_c[4];

    arbiter_k #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .req2(req2), .req3(req3),
        .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2), .gnt3(gnt3)
    );

    always #5 clk = ~clk;

    task automatic vec(input logic r, input logic [3:0] rq, input logic [3:0] e);
        @(negedge clk);
        rst = r;
        {req3, req2, req1, req0} = rq;
        exp_q.push_back(e);
        tag_q.push_back(vec_id);
        vec_id++;
    endtask

    // Monitor: one expected grant vector per clock edge while directed vectors are pending.
    initial begin
        logic [3:0] g, e, rq;
        int t;
        forever begin
            @(posedge clk);
            #1;
            g  = {gnt3, gnt2, gnt1, gnt0};
            rq = {req3, req2, req1, req0};
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL vec%0d gnt got %b want %b", t, g, e);
                end
            end else if (soak) begin
                checks++;
                if ($countones(g) > 1) begin
                    errors++;
                    $display("FAIL soak_onehot gnt got %b want at most one bit", g);
                end
                checks++;
                if ((g & ~rq) != 4'b0000) begin
                    errors++;
                    $display("FAIL soak_legal gnt got %b req %b want no grant without request", g, rq);
                end
                for (int i = 0; i < 4; i++) begin
                    if (rq[i] && !g[i]) wait_c[i]++;
                    else wait_c[i] = 0;
                    checks++;
                    if (wait_c[i] > WAIT_BOUND) begin
                        errors++;
                        $display("FAIL soak_wait%0d waited %0d want <= %0d", i, wait_c[i], WAIT_BOUND);
                        wait_c[i] = 0;
                    end
                end
            end
        end
    end

    initial begin
        int budget;

        // Reset with every request high, then ptr=0 picks master 0.
        vec(1'b1, 4'b1111, 4'b0000);
        // Full contention: 4 cycles per master, no idle gaps.
        for (int k = 0; k < 20; k++) begin
            logic [3:0] one;
            one = 4'b0001;
            vec(1'b0, 4'b1111, one << ((k / MAX_HOLD) % 4));
        end
        // Reset mid-grant drops the grant at that edge.
        vec(1'b1, 4'b0000, 4'b0000);

        // Lone requester 2 keeps the grant for 20 cycles, then releases (ptr=3).
        for (int k = 0; k < 20; k++) vec(1'b0, 4'b0100, 4'b0100);
        vec(1'b0, 4'b0000, 4'b0000);
        // ptr=3 selects master 3 ahead of master 0.
        vec(1'b0, 4'b1001, 4'b1000);
        // Master 3 releases alone: IDLE with ptr=0, then req0/req1 together -> master 0.
        vec(1'b0, 4'b0000, 4'b0000);
        vec(1'b0, 4'b0011, 4'b0001);
        // Master 0 releases, master 1 takes over; master 3 joins.
        vec(1'b0, 4'b0010, 4'b0010);
        vec(1'b0, 4'b1010, 4'b0010);
        // Early release of master 1 with req0 and req3 waiting: scan from 2 -> master 3.
        vec(1'b0, 4'b1001, 4'b1000);
        vec(1'b0, 4'b1001, 4'b1000);
        vec(1'b0, 4'b0001, 4'b0001);
        vec(1'b0, 4'b0000, 4'b0000);
        // ptr=1, lone master 0: counter saturates without forcing rotation.
        for (int k = 0; k < 7; k++) vec(1'b0, 4'b0001, 4'b0001);
        // Saturated counter plus a new contender: immediate expiry to master 1.
        vec(1'b0, 4'b0011, 4'b0010);
        vec(1'b0, 4'b0000, 4'b0000);

        budget = 50;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end

        // Random soak with requests biased high so waits actually build up.
        @(negedge clk);
        for (int i = 0; i < 4; i++) wait_c[i] = 0;
        soak = 1'b1;
        for (int k = 0; k < 125; k++) begin
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 3) != 0);
            req2 = ($urandom_range(0, 3) != 0);
            req3 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        soak = 1'b0;
        {req3, req2, req1, req0} = 4'b0000;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
